// File: rtl/async_fifo_core.sv
// async_fifo_core: single-clock show-ahead FIFO. It is the common-clock
// counterpart and the cycle-accurate flag/data reference for the dual-clock FIFO.
// Optional macro ASYNC_FIFO_CORE_ERR_EN adds sticky overflow/underflow outputs.
// DEPTH must be a power of two and at least 2.
module async_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty
`ifdef ASYNC_FIFO_CORE_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en, rd_en;

    // Flags are decoded from the registered pointers only.
    assign rempty = (wptr_q == rptr_q);
    assign wfull  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                    (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

    // The head entry is visible without a read request; an empty FIFO shows zero.
    assign rdata = rempty ? '0 : mem_q[rptr_q[ADDR_WIDTH-1:0]];

    // A request is accepted only if its flag is clear; reset blocks both.
    assign wr_en = winc && !wfull  && !rst;
    assign rd_en = rinc && !rempty && !rst;

    // Next-state pointers: advance by one per accepted operation.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array is not reset; only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
    end

`ifdef ASYNC_FIFO_CORE_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set by a rejected request, cleared only by reset.
    always_comb begin
        overflow_d  = overflow_q  || (winc && wfull);
        underflow_d = underflow_q || (rinc && rempty);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Directed bench for async_fifo_core: reset, show-ahead, full/empty boundaries,
// simultaneous operations, pointer wrap and mid-stream reset.
module tb_async_fifo_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic [7:0] wdata;
    logic       wfull;
    logic       rinc;
    logic [7:0] rdata;
    logic       rempty;
`ifdef ASYNC_FIFO_CORE_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_d;

    async_fifo_core #(.DATA_WIDTH(8), .DEPTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty)
`ifdef ASYNC_FIFO_CORE_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
        #1;
        tick(); tick();
        rst = 1'b0;
        chk1("reset_rempty", rempty, 1'b1);
        chk1("reset_wfull",  wfull,  1'b0);
        chk8("reset_rdata",  rdata,  8'h00);
`ifdef ASYNC_FIFO_CORE_ERR_EN
        chk1("reset_overflow",  overflow,  1'b0);
        chk1("reset_underflow", underflow, 1'b0);
`endif

        // Single word show-ahead, then pop.
        winc = 1'b1; wdata = 8'hA5; tick(); winc = 1'b0;
        chk1("single_rempty", rempty, 1'b0);
        chk8("single_rdata",  rdata,  8'hA5);
        rinc = 1'b1; tick(); rinc = 1'b0;
        chk1("single_pop_rempty", rempty, 1'b1);
        chk8("single_pop_rdata",  rdata,  8'h00);

        // Fill to 32 entries, drop the 33rd write, drain in order.
        for (int i = 0; i < 32; i++) begin
            winc = 1'b1; wdata = 8'(i); tick();
            if (i == 30) chk1("fill31_wfull", wfull, 1'b0);
        end
        chk1("fill32_wfull", wfull, 1'b1);
        wdata = 8'hFF; tick(); winc = 1'b0;
        chk1("overfill_wfull", wfull, 1'b1);
        chk8("overfill_head",  rdata, 8'h00);
`ifdef ASYNC_FIFO_CORE_ERR_EN
        chk1("overfill_overflow", overflow, 1'b1);
`endif
        for (int i = 0; i < 32; i++) begin
            chk8("drain_rdata", rdata, 8'(i));
            rinc = 1'b1; tick(); rinc = 1'b0;
            if (i == 0) chk1("drain_first_wfull", wfull, 1'b0);
        end
        chk1("drain_rempty", rempty, 1'b1);
        chk8("drain_rdata_zero", rdata, 8'h00);

        // Simultaneous read and write while full: read wins, write rejected.
        winc = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wdata = 8'(i); tick();
        end
        chk1("refill_wfull", wfull, 1'b1);
        rinc = 1'b1; wdata = 8'h77; tick(); winc = 1'b0; rinc = 1'b0;
        chk1("full_both_wfull", wfull, 1'b0);
        chk8("full_both_head",  rdata, 8'h01);
        for (int i = 1; i < 32; i++) begin
            chk8("full_both_drain", rdata, 8'(i));
            rinc = 1'b1; tick(); rinc = 1'b0;
        end
        chk1("full_both_rempty", rempty, 1'b1);

        // Simultaneous read and write while empty: write wins, read ignored.
        winc = 1'b1; rinc = 1'b1; wdata = 8'h3C; tick(); winc = 1'b0; rinc = 1'b0;
        chk1("empty_both_rempty", rempty, 1'b0);
        chk8("empty_both_rdata",  rdata,  8'h3C);
`ifdef ASYNC_FIFO_CORE_ERR_EN
        chk1("empty_both_underflow", underflow, 1'b1);
`endif
        rinc = 1'b1; tick(); rinc = 1'b0;
        chk1("empty_both_pop_rempty", rempty, 1'b1);

        // Alternating write/read with random data; pointers wrap several times.
        for (int c = 0; c < 200; c++) begin
            if ((c % 2) == 0) begin
                winc = 1'b1; wdata = 8'($urandom);
                sb.push_back(wdata);
            end else begin
                exp_d = sb.pop_front();
                chk8("alt_rdata", rdata, exp_d);
                rinc = 1'b1;
            end
            tick();
            winc = 1'b0; rinc = 1'b0;
            chk1("alt_wfull", wfull, 1'b0);
        end
        chk1("alt_end_rempty", rempty, 1'b1);

        // Mid-stream reset with a concurrent write request.
        for (int i = 0; i < 10; i++) begin
            winc = 1'b1; wdata = 8'(8'h40 + i); tick();
        end
        chk8("prereset_head", rdata, 8'h40);
        rst = 1'b1; tick(); rst = 1'b0; winc = 1'b0;
        chk1("midrst_rempty", rempty, 1'b1);
        chk1("midrst_wfull",  wfull,  1'b0);
        chk8("midrst_rdata",  rdata,  8'h00);
`ifdef ASYNC_FIFO_CORE_ERR_EN
        chk1("midrst_overflow",  overflow,  1'b0);
        chk1("midrst_underflow", underflow, 1'b0);
        rinc = 1'b1; tick(); rinc = 1'b0;
        chk1("underflow_set", underflow, 1'b1);
        tick(); tick();
        chk1("underflow_hold", underflow, 1'b1);
        chk1("underflow_no_overflow", overflow, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/async_fifo_core.md
Name: async_fifo_core

Overview:
- Single-clock FIFO with the same interface semantics as the team's async FIFO: write port (winc/wdata/wfull) and read port (rinc/rdata/rempty).
- Intended as the common-clock variant and as the cycle-accurate golden reference for the dual-clock FIFO flag and data checks.
- Show-ahead (first-word fall-through) read: head entry always visible on rdata.

Parameters:
- DATA_WIDTH, 8, width of wdata/rdata in bits.
- DEPTH, 32, number of entries; must be a power of two, at least 2; ADDR_WIDTH = $clog2(DEPTH) derived internally.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- winc  input  1  write request; wdata pushed when winc=1 and wfull=0.
- wdata  input  DATA_WIDTH  write data.
- wfull  output  1  FIFO holds DEPTH entries.
- rinc  input  1  read request; head entry popped when rinc=1 and rempty=0.
- rdata  output  DATA_WIDTH  current head entry (show-ahead).
- rempty  output  1  FIFO holds 0 entries.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array; no reset on array contents.
- Pointers: wptr, rptr, each ADDR_WIDTH+1 bits (extra wrap bit), binary, increment by 1 per accepted op, natural wrap modulo 2*DEPTH.
- Accepted write: winc && !wfull → mem[wptr[ADDR_WIDTH-1:0]] <= wdata; wptr+1.
- Accepted read: rinc && !rempty → rptr+1.
- Flags combinational from registered pointers: rempty = (wptr == rptr); wfull = (address bits equal) && (wrap bits differ). Both therefore change in the cycle after the causing edge.
- rdata = mem[rptr[ADDR_WIDTH-1:0]] combinationally when !rempty; forced to 0 when rempty.
- Zero-latency show-ahead: word written at edge N is on rdata after edge N, poppable at edge N+1.
- Write while full: ignored; pointer and memory unchanged; no error.
- Read while empty: ignored; rptr unchanged.
- Simultaneous winc and rinc, neither flag set: both accepted; occupancy unchanged.
- Simultaneous ops when full: read accepted, write rejected (wfull gates same-cycle write); next cycle wfull=0.
- Simultaneous ops when empty: write accepted, read rejected; next cycle rempty=0, rdata = written word.
- Reset: wptr=rptr=0 → rempty=1, wfull=0, rdata=0 in the cycle after the reset edge. Mid-operation reset discards all contents; winc/rinc ignored in any cycle rst=1.
- Ordering: strict FIFO; data never duplicated, dropped (except rejected writes), or reordered.

Optional Feature:
- Macro ASYNC_FIFO_CORE_ERR_EN.
- Defined:
  - adds outputs overflow (1 bit) and underflow (1 bit), registered, sticky.
  - overflow sets on the edge where winc=1 and wfull=1; underflow sets on the edge where rinc=1 and rempty=1.
  - Both cleared only by rst; reset value 0.
- Not defined: ports absent; rejected ops are silent, as above.

Test Plan:
- Reset, then winc=1 with wdata=8'hA5 for one cycle → next cycle rempty=0, rdata=8'hA5; rinc one cycle → rempty=1, rdata=0.
- Write 32 words 0x00..0x1F back-to-back → wfull=1 after the 32nd edge; 33rd write 0xFF is dropped; 32 reads return 0x00..0x1F in order, then rempty=1.
- Fill to 32, then winc=rinc=1 with wdata=0x77 → read pops 0x00, write rejected, wfull=0 next cycle; occupancy 31, 0x77 never read.
- From empty, winc=rinc=1 with wdata=0x3C → write accepted, read ignored; rempty=0, rdata=0x3C.
- Alternate write/read (winc on even cycles, rinc on odd) for 200 cycles with random data → pointers wrap multiple times, every read matches the scoreboard, wfull never 1.
- Write 10 words, assert rst mid-stream with winc=1 → next cycle rempty=1, wfull=0, rdata=0; with ASYNC_FIFO_CORE_ERR_EN: a read while empty sets underflow=1, which holds until rst.
